// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the MIPS multicycle control slice.
//   - mc_state_e : 4-bit sequencer state encoding (S_IDLE = 0)
//   - OP_*       : supported instruction[31:26] opcodes
//   - ULA_*      : ula_operation classes sent to ula_control
//   - SRCB_*     : ALUSrcB select encodings
//   - PCSRC_*    : PCSource select encodings
//   - mc_ctrl_t  : the Moore output bundle held per state
//   - mc_decode  : state -> Moore outputs
//   - mc_op_legal: opcode support check
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } mc_state_e;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] ula_op;
        logic [1:0] pc_source;
    } mc_ctrl_t;

    function automatic logic mc_op_legal(input logic [OPCODE_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The opcode only matters on entry to S_BRANCH, where it picks which
    // branch condition is armed; that entry happens out of S_DECODE.
    function automatic mc_ctrl_t mc_decode(input mc_state_e st,
                                           input logic [OPCODE_W-1:0] op);
        mc_ctrl_t c;
        c        = '0;
        c.ula_op = ULA_ADD;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.ula_op    = ULA_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_IMMWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.ula_op    = ULA_SUB;
                c.pc_source = PCSRC_ALUOUT;
                c.branch_eq = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// mc_next_state: combinational next-state function of the multicycle
// sequencer.
//   state_i  : current state
//   opcode_i : instruction[31:26] from the instruction register
//   next_o   : state to enter on the next enabled clock
import mc_pkg::*;

module mc_next_state (
    input  mc_state_e             state_i,
    input  logic [OPCODE_W-1:0]   opcode_i,
    output mc_state_e             next_o
);

    always_comb begin
        next_o = S_FETCH;
        case (state_i)
            S_IDLE:   next_o = S_FETCH;
            S_FETCH:  next_o = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW, OP_ADDI: next_o = S_MEMADR;
                    OP_RTYPE:              next_o = S_EXEC;
                    OP_BEQ, OP_BNE:        next_o = S_BRANCH;
                    OP_J:                  next_o = S_JUMP;
                    default:               next_o = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (opcode_i)
                    OP_LW:   next_o = S_MEMRD;
                    OP_SW:   next_o = S_MEMWR;
                    OP_ADDI: next_o = S_IMMWB;
                    default: next_o = S_FETCH;
                endcase
            end
            S_MEMRD:  next_o = S_MEMWB;
            S_EXEC:   next_o = S_ALUWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP:
                      next_o = S_FETCH;
            // Unused encodings recover by restarting at fetch.
            default:  next_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore sequencer for the multicycle MIPS datapath.
// Spreads each instruction over 3-5 clocks and drives every datapath select
// and write enable.
//   clock, reset (async, active-high), enable (stall: holds state, kills
//   write enables)
//   opcode, ula_zero_flag          : inputs from IR and ULA
//   pc_en                          : PCWrite | (beq & zero) | (bne & ~zero)
//   IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ula_operation, PCSource : datapath controls
//   illegal_op                     : pulse in S_DECODE on unsupported opcode
//   state                          : current state, for debug
// Optional: MC_PERF_COUNTERS_EN adds cycle_count / instr_count outputs.
import mc_pkg::*;

module mips_multicycle_control (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ula_zero_flag,
    output logic                pc_en,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ula_operation,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic [3:0]          state
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]         cycle_count,
    output logic [31:0]         instr_count
`endif
);

    mc_state_e state_q, state_d, nxt_state;
    mc_ctrl_t  ctrl_q, ctrl_d;

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q;
    logic [31:0] instr_count_q;
`endif

    mc_next_state u_next_state (
        .state_i  (state_q),
        .opcode_i (opcode),
        .next_o   (nxt_state)
    );

    // The Moore outputs are registered alongside the state: the register
    // loads the decode of the state being entered, so it always matches
    // state_q and simply holds while stalled.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        if (enable) begin
            state_d = nxt_state;
            ctrl_d  = mc_decode(nxt_state, opcode);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
`ifdef MC_PERF_COUNTERS_EN
            cycle_count_q <= '0;
            instr_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef MC_PERF_COUNTERS_EN
            if (enable) begin
                cycle_count_q <= cycle_count_q + 32'd1;
                if (state_q == S_FETCH) begin
                    instr_count_q <= instr_count_q + 32'd1;
                end
            end
`endif
        end
    end

    // Strobes are gated by enable combinationally so a stall takes effect
    // in the same cycle; selects keep their registered state values.
    assign pc_en    = enable & (ctrl_q.pc_write
                              | (ctrl_q.branch_eq &  ula_zero_flag)
                              | (ctrl_q.branch_ne & ~ula_zero_flag));
    assign MemRead  = enable & ctrl_q.mem_read;
    assign MemWrite = enable & ctrl_q.mem_write;
    assign IRWrite  = enable & ctrl_q.ir_write;
    assign RegWrite = enable & ctrl_q.reg_write;

    assign IorD          = ctrl_q.iord;
    assign RegDst        = ctrl_q.reg_dst;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUSrcA       = ctrl_q.alu_src_a;
    assign ALUSrcB       = ctrl_q.alu_src_b;
    assign ula_operation = ctrl_q.ula_op;
    assign PCSource      = ctrl_q.pc_source;

    assign illegal_op = enable & (state_q == S_DECODE) & ~mc_op_legal(opcode);
    assign state      = state_q;

`ifdef MC_PERF_COUNTERS_EN
    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: self-checking bench for the multicycle
// sequencer. A per-instruction model lists the states each opcode walks
// through and the control values the datapath must see in each of them.
module tb_mips_multicycle_control;
    import mc_pkg::*;

    localparam int DONE = -1;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [5:0]  opcode;
    logic        ula_zero_flag;
    logic        pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic        RegWrite, ALUSrcA, illegal_op;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ula_operation;
    logic [3:0]  state;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int total = 0;
    int bad   = 0;

    mips_multicycle_control dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .opcode        (opcode),
        .ula_zero_flag (ula_zero_flag),
        .pc_en         (pc_en),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ula_operation (ula_operation),
        .PCSource      (PCSource),
        .illegal_op    (illegal_op),
        .state         (state)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .instr_count   (instr_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b001000, 6'b000010};
    endfunction

    // State visited at step k of an instruction (DONE once it is over).
    function automatic int state_at(input logic [5:0] op, input int k);
        if (k == 0) return int'(S_FETCH);
        if (k == 1) return int'(S_DECODE);
        case (op)
            6'b100011: case (k)
                2: return int'(S_MEMADR);
                3: return int'(S_MEMRD);
                4: return int'(S_MEMWB);
                default: return DONE;
            endcase
            6'b101011: case (k)
                2: return int'(S_MEMADR);
                3: return int'(S_MEMWR);
                default: return DONE;
            endcase
            6'b001000: case (k)
                2: return int'(S_MEMADR);
                3: return int'(S_IMMWB);
                default: return DONE;
            endcase
            6'b000000: case (k)
                2: return int'(S_EXEC);
                3: return int'(S_ALUWB);
                default: return DONE;
            endcase
            6'b000100, 6'b000101: return (k == 2) ? int'(S_BRANCH) : DONE;
            6'b000010:            return (k == 2) ? int'(S_JUMP) : DONE;
            default:              return DONE;
        endcase
    endfunction

    // Expected {pc_en,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,
    // RegWrite,ALUSrcA,ALUSrcB,ula_operation,PCSource,illegal_op,state}.
    function automatic logic [20:0] expect_vec(input int st, input logic [5:0] op,
                                               input bit en, input bit z);
        bit pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0;
        bit rw = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 2'b00, pcs = 2'b00;
        logic [2:0] ula = 3'b000;
        if (st == int'(S_FETCH))  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
        if (st == int'(S_DECODE)) begin srcb = 2'b11; ill = en && !op_ok(op); end
        if (st == int'(S_MEMADR)) begin srca = 1; srcb = 2'b10; end
        if (st == int'(S_MEMRD))  begin mrd = 1; iord = 1; end
        if (st == int'(S_MEMWR))  begin mwr = 1; iord = 1; end
        if (st == int'(S_MEMWB))  begin rw = 1; m2r = 1; end
        if (st == int'(S_EXEC))   begin srca = 1; ula = 3'b010; end
        if (st == int'(S_ALUWB))  begin rw = 1; rdst = 1; end
        if (st == int'(S_IMMWB))  rw = 1;
        if (st == int'(S_BRANCH)) begin
            srca = 1; ula = 3'b001; pcs = 2'b01;
            pcw = (op == 6'b000100) ? z : !z;
        end
        if (st == int'(S_JUMP))   begin pcw = 1; pcs = 2'b10; end
        if (!en) begin pcw = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; end
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, ula, pcs,
                ill, 4'(st)};
    endfunction

    function automatic logic [20:0] actual_vec();
        return {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ula_operation, PCSource,
                illegal_op, state};
    endfunction

    // Entered and left at posedge+1; the check happens on the falling edge.
    task automatic step(input string tag, input int st, input logic [5:0] op,
                        input bit en, input bit z);
        enable        = en;
        ula_zero_flag = z;
        opcode        = op;
        #4;
        check_eq(tag, 32'(actual_vec()), 32'(expect_vec(st, op, en, z)));
        @(posedge clock);
        #1;
    endtask

    // zmode: 0/1 fixed zero flag, 2 random. stall_n idle cycles are inserted
    // before step stall_k; stall_pct adds random stalls elsewhere.
    task automatic run_instr(input string tag, input logic [5:0] op,
                             input int stall_pct, input int stall_k,
                             input int stall_n, input int zmode);
        int k = 0;
        bit z;
        while (state_at(op, k) != DONE) begin
            z = (zmode == 2) ? bit'($urandom_range(1)) : bit'(zmode);
            if (k == stall_k) begin
                for (int i = 0; i < stall_n; i++) step({tag, "_hold"}, state_at(op, k), op, 1'b0, z);
            end
            if (int'($urandom_range(99)) < stall_pct) begin
                step({tag, "_stall"}, state_at(op, k), op, 1'b0, z);
            end else begin
                step(tag, state_at(op, k), op, 1'b1, z);
                k++;
            end
        end
    endtask

    logic [5:0] ops [7];
    logic [5:0] rop;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cyc0, ins0;
`endif

    initial begin
        ops[0] = OP_RTYPE; ops[1] = OP_LW;  ops[2] = OP_SW; ops[3] = OP_BEQ;
        ops[4] = OP_BNE;   ops[5] = OP_ADDI; ops[6] = OP_J;
        reset = 1'b1; enable = 1'b1; opcode = '0; ula_zero_flag = 1'b0;
        #2;
        check_eq("reset_outputs", 32'(actual_vec()), 32'(expect_vec(int'(S_IDLE), 6'd0, 1'b1, 1'b0)));
        @(posedge clock); #1;
        reset = 1'b0;
        step("idle", int'(S_IDLE), OP_LW, 1'b1, 1'b0);

        // lw end to end, no stalls
        run_instr("lw", OP_LW, 0, -1, 0, 0);
        // beq / bne, both zero flag values
        run_instr("beq_z1", OP_BEQ, 0, -1, 0, 1);
        run_instr("beq_z0", OP_BEQ, 0, -1, 0, 0);
        run_instr("bne_z1", OP_BNE, 0, -1, 0, 1);
        run_instr("bne_z0", OP_BNE, 0, -1, 0, 0);
        // unsupported opcode
        run_instr("illegal", 6'b111111, 0, -1, 0, 0);
        // 3-cycle stall inside S_EXEC
        run_instr("rtype_stall", OP_RTYPE, 0, 2, 3, 0);
        // stall in fetch and decode too
        run_instr("sw_stall", OP_SW, 0, 0, 2, 0);
        run_instr("addi_stall", OP_ADDI, 0, 1, 1, 0);

`ifdef MC_PERF_COUNTERS_EN
        cyc0 = cycle_count; ins0 = instr_count;
        run_instr("perf_sw", OP_SW, 0, -1, 0, 0);
        run_instr("perf_j", OP_J, 0, -1, 0, 0);
        check_eq("perf_cycles", cycle_count - cyc0, 32'd7);
        check_eq("perf_instrs", instr_count - ins0, 32'd2);
`endif

        // Reset in the middle of a store.
        step("rst_f", int'(S_FETCH), OP_SW, 1'b1, 1'b0);
        step("rst_d", int'(S_DECODE), OP_SW, 1'b1, 1'b0);
        step("rst_a", int'(S_MEMADR), OP_SW, 1'b1, 1'b0);
        #1;
        check_eq("memwr_before_reset", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("reset_mid_memwr", 32'(actual_vec()), 32'(expect_vec(int'(S_IDLE), OP_SW, 1'b1, 1'b0)));
        @(posedge clock); #1;
        check_eq("reset_held", 32'(actual_vec()), 32'(expect_vec(int'(S_IDLE), OP_SW, 1'b1, 1'b0)));
        reset = 1'b0;
        step("idle2", int'(S_IDLE), OP_SW, 1'b1, 1'b0);
        step("first_fetch", int'(S_FETCH), OP_SW, 1'b1, 1'b0);
        step("after_fetch", int'(S_DECODE), OP_SW, 1'b1, 1'b0);
        step("after_adr", int'(S_MEMADR), OP_SW, 1'b1, 1'b0);
        step("after_wr", int'(S_MEMWR), OP_SW, 1'b1, 1'b0);

        // Random instruction stream with random stalls and zero flags.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(8) < 7) rop = ops[$urandom_range(6)];
            else rop = 6'($urandom);
            run_instr("rand", rop, 20, -1, 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
